encode_frame_controller: RTL

ENCODE_FRAME_CONTROLLER -- requirements
Module: encode_frame_controller

---
 rtl/encode_frame_controller_pkg.sv | 22 ++
 rtl/encode_frame_controller_if.sv | 32 +++
 rtl/encode_frame_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/encode_frame_controller_pkg.sv
// Shared polar-code defaults and the frame controller state encoding.
package polar_pkg;

  localparam int N_DEF       = 2048;
  localparam int K_DEF       = 1024;
  localparam int P_DEF       = N_DEF - K_DEF;
  localparam int W_DEF       = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT,
    UNLOAD
  } state_t;

  // Word-counter width; a single-word frame still needs a 1-bit counter
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/encode_frame_controller_if.sv
// Stream-in, encoder and stream-out signals of the encode frame controller.
interface encode_frame_controller_if
  import polar_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF,
  parameter int W = W_DEF
);

  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         enc_in_valid;
  logic [K-1:0] enc_data;
  logic         enc_out_valid;
  logic [N-1:0] enc_encoded;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  modport master (
    input  s_valid, s_data, enc_out_valid, enc_encoded, m_ready,
    output s_ready, enc_in_valid, enc_data, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, enc_out_valid, enc_encoded, m_ready,
    input  s_ready, enc_in_valid, enc_data, m_valid, m_data, m_last
  );

endinterface

// File: rtl/encode_frame_controller.sv
// Collects K message bits from a W-bit stream, fires the encoder once, waits
// (bounded) for its N-bit result and streams the codeword back out in W-bit words.
module encode_frame_controller
  import polar_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K       = K_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  encode_frame_controller_if.master  bus,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int WORDS_IN  = K / W;
  localparam int WORDS_OUT = N / W;
  localparam int WR_W      = cnt_w(WORDS_IN);
  localparam int RD_W      = cnt_w(WORDS_OUT);
  localparam int TM_W      = $clog2(TIMEOUT + 1);

  if ((K % W) != 0 || (N % W) != 0 || K < W || TIMEOUT < 1) begin : g_param_chk
    $error("encode_frame_controller: K and N must be non-zero multiples of W, TIMEOUT >= 1");
  end

  state_t          r_state;
  state_t          w_next;
  logic [WR_W-1:0] r_wr;
  logic [RD_W-1:0] r_rd;
  logic [TM_W-1:0] r_timer;
  logic            r_err;
  logic [K-1:0]    r_enc_data;
  logic [N-1:0]    r_buf;

  logic w_in_fire;
  logic w_out_fire;
  logic w_last_in;
  logic w_last_out;
  logic w_tmo;

  assign w_in_fire  = bus.s_valid && bus.s_ready;
  assign w_out_fire = bus.m_valid && bus.m_ready;
  assign w_last_in  = (r_wr == WR_W'(WORDS_IN - 1));
  assign w_last_out = (r_rd == RD_W'(WORDS_OUT - 1));
  assign w_tmo      = (r_timer == TM_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:    if (w_in_fire && w_last_in) w_next = FIRE;
      FIRE:    w_next = WAIT;
      WAIT: begin
        if (bus.enc_out_valid) w_next = UNLOAD;
        else if (w_tmo)        w_next = LOAD;
      end
      UNLOAD:  if (w_out_fire && w_last_out) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  // Control state: async reset; the timer leaves WAIT before it could wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
      r_wr    <= '0;
      r_rd    <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        LOAD:   if (w_in_fire && !w_last_in) r_wr <= r_wr + WR_W'(1);
        FIRE:   r_timer <= '0;
        WAIT: begin
          if (bus.enc_out_valid) begin
            r_timer <= '0;
          end else if (w_tmo) begin
            r_timer <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_err   <= 1'b1;
          end else begin
            r_timer <= r_timer + TM_W'(1);
          end
        end
        UNLOAD: begin
          if (w_out_fire) begin
            if (w_last_out) begin
              r_rd <= '0;
              r_wr <= '0;
            end else begin
              r_rd <= r_rd + RD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; nothing observable reads them until rewritten
  always_ff @(posedge clk) begin
    if (w_in_fire) r_enc_data[r_wr*W +: W] <= bus.s_data;
    if (r_state == WAIT && bus.enc_out_valid) r_buf <= bus.enc_encoded;
  end

  assign bus.s_ready      = (r_state == LOAD) && rst_n;
  assign bus.enc_in_valid = (r_state == FIRE);
  assign bus.enc_data     = r_enc_data;
  assign bus.m_valid      = (r_state == UNLOAD);
  assign bus.m_data       = r_buf[r_rd*W +: W];
  assign bus.m_last       = (r_state == UNLOAD) && w_last_out;
  assign busy             = (r_state != LOAD) || (r_wr != '0);
  assign timeout_err      = r_err;

endmodule
